// File: rtl/aexm_pipe_sched.sv
// Pipeline sequencer for the AEXM core: decode/execute advance enables, multi-cycle
// op holds, cache-busy holds, interrupt injection and a saturating stall counter.
module aexm_pipe_sched #(
    parameter int MC_CYCLES   = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   gclk,
    input  logic                   grst,
    input  logic                   fSTALL,
    input  logic                   icache_busy,
    input  logic                   dcache_busy,
    input  logic                   in_dslot,
    input  logic                   int_req,
    input  logic                   int_enable,
    input  logic                   perf_clr,
    output logic                   d_en,
    output logic                   x_en,
    output logic                   cpu_interrupt,
    output logic                   int_ack,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MCOP, INT} state_t;

    // The advance cycle of a multi-cycle op counts toward MC_CYCLES, so MCOP
    // itself lasts MC_CYCLES-1 cycles, counting down to zero.
    localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 2);

    state_t                 state;
    logic [3:0]             mcCnt;
    logic                   intArmed;
    logic                   busy;
    logic                   advance;
    logic                   intTake;
    logic [STALL_CNT_W-1:0] stallCnt;

    assign busy    = icache_busy | dcache_busy;
    assign advance = ((state == RUN) || (state == INT)) && !busy;
    assign intTake = int_req && int_enable && intArmed && !in_dslot;

    assign d_en          = advance;
    assign x_en          = advance;
    assign cpu_interrupt = (state == INT);
    assign int_ack       = (state == INT) && advance;
    assign stall_cycles  = stallCnt;

    always_ff @(posedge gclk) begin
        if (!grst) begin
            state    <= RUN;
            mcCnt    <= 4'd0;
            intArmed <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (!busy && fSTALL) begin
                        state <= MCOP;
                        mcCnt <= MC_LOAD;
                    end else if (!busy && intTake) begin
                        state <= INT;
                    end
                end
                MCOP: begin
                    if (mcCnt == 4'd0) state <= RUN;
                    else               mcCnt <= mcCnt - 4'd1;
                end
                INT: begin
                    if (advance) state <= RUN;
                end
                default: state <= RUN;
            endcase
            // A dropped request re-arms even on the ack cycle, so a level that
            // fell while waiting in INT can be retaken.
            if (int_ack)  intArmed <= 1'b0;
            if (!int_req) intArmed <= 1'b1;
        end
    end

    always_ff @(posedge gclk) begin
        if (!grst || perf_clr)              stallCnt <= '0;
        else if (!advance && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
    end

endmodule

// File: tb/tb_aexm_pipe_sched.sv
// Directed bench for aexm_pipe_sched: inputs driven just after the falling edge,
// outputs checked 1ns later, state advancing on the rising edge in between.
module tb_aexm_pipe_sched;

    logic        gclk = 1'b0;
    logic        grst;
    logic        fSTALL, icache_busy, dcache_busy, in_dslot;
    logic        int_req, int_enable, perf_clr;
    logic        d_en, x_en, cpu_interrupt, int_ack;
    logic [15:0] stall_cycles;
    logic        d_en4, x_en4, ci4, ack4;
    logic [3:0]  stall4;

    int tests_run = 0;
    int fails     = 0;

    always #5 gclk = ~gclk;

    aexm_pipe_sched #(.MC_CYCLES(3), .STALL_CNT_W(16)) dut (
        .gclk(gclk), .grst(grst), .fSTALL(fSTALL), .icache_busy(icache_busy),
        .dcache_busy(dcache_busy), .in_dslot(in_dslot), .int_req(int_req),
        .int_enable(int_enable), .perf_clr(perf_clr), .d_en(d_en), .x_en(x_en),
        .cpu_interrupt(cpu_interrupt), .int_ack(int_ack), .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy sharing all stimulus, used for the saturation check.
    aexm_pipe_sched #(.MC_CYCLES(3), .STALL_CNT_W(4)) dut4 (
        .gclk(gclk), .grst(grst), .fSTALL(fSTALL), .icache_busy(icache_busy),
        .dcache_busy(dcache_busy), .in_dslot(in_dslot), .int_req(int_req),
        .int_enable(int_enable), .perf_clr(perf_clr), .d_en(d_en4), .x_en(x_en4),
        .cpu_interrupt(ci4), .int_ack(ack4), .stall_cycles(stall4)
    );

    // {d_en, x_en, cpu_interrupt, int_ack}
    task automatic test_reset();
        grst = 1'b0; fSTALL = 0; icache_busy = 0; dcache_busy = 0; in_dslot = 0;
        int_req = 0; int_enable = 0; perf_clr = 0;
        repeat (2) @(negedge gclk);
        grst = 1'b1;
        #1;
        tests_run++;
        if ({d_en, x_en, cpu_interrupt, int_ack} !== 4'b1100 || stall_cycles !== 16'd0) begin
            fails++;
            $display("FAIL reset: outs=%b stall=%0d want outs=1100 stall=0",
                     {d_en, x_en, cpu_interrupt, int_ack}, stall_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk); #1;
            tests_run++;
            if ({d_en, x_en, cpu_interrupt, int_ack} !== 4'b1100 || stall_cycles !== 16'd0) begin
                fails++;
                $display("FAIL idle[%0d]: outs=%b stall=%0d want outs=1100 stall=0",
                         i, {d_en, x_en, cpu_interrupt, int_ack}, stall_cycles);
            end
        end
    endtask

    task automatic test_mcop();
        logic exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk);
            fSTALL = (i == 0);
            #1;
            tests_run++;
            if (d_en !== exp[i] || x_en !== exp[i]) begin
                fails++;
                $display("FAIL mcop[%0d]: d_en=%b x_en=%b want %b", i, d_en, x_en, exp[i]);
            end
        end
        tests_run++;
        if (stall_cycles !== 16'd2) begin
            fails++;
            $display("FAIL mcop_stall: got %0d want 2", stall_cycles);
        end
    endtask

    task automatic test_busy();
        for (int i = 0; i < 5; i++) begin
            @(negedge gclk);
            dcache_busy = 1'b1;
            #1;
            tests_run++;
            if (d_en !== 1'b0 || x_en !== 1'b0) begin
                fails++;
                $display("FAIL busy[%0d]: d_en=%b x_en=%b want 0", i, d_en, x_en);
            end
        end
        @(negedge gclk);
        dcache_busy = 1'b0;
        perf_clr    = 1'b1;
        #1;
        tests_run++;
        if (d_en !== 1'b1 || stall_cycles !== 16'd7) begin
            fails++;
            $display("FAIL busy_end: d_en=%b stall=%0d want d_en=1 stall=7", d_en, stall_cycles);
        end
        @(negedge gclk);
        perf_clr = 1'b0;
        #1;
        tests_run++;
        if (stall_cycles !== 16'd0) begin
            fails++;
            $display("FAIL perf_clr: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_int_dslot();
        int_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            int_req  = 1'b1;
            in_dslot = (i < 2);
            #1;
            tests_run++;
            if ({d_en, x_en, cpu_interrupt, int_ack} !== 4'b1100) begin
                fails++;
                $display("FAIL int_dslot[%0d]: outs=%b want 1100", i, {d_en, x_en, cpu_interrupt, int_ack});
            end
        end
        @(negedge gclk); #1;
        tests_run++;
        if ({d_en, cpu_interrupt, int_ack} !== 3'b111) begin
            fails++;
            $display("FAIL int_take: d_en/ci/ack=%b want 111", {d_en, cpu_interrupt, int_ack});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge gclk); #1;
            tests_run++;
            if ({cpu_interrupt, int_ack} !== 2'b00) begin
                fails++;
                $display("FAIL int_held[%0d]: ci/ack=%b want 00", i, {cpu_interrupt, int_ack});
            end
        end
        @(negedge gclk); int_req = 1'b0;
        @(negedge gclk); int_req = 1'b1;
        @(negedge gclk); #1;
        tests_run++;
        if ({d_en, cpu_interrupt, int_ack} !== 3'b111) begin
            fails++;
            $display("FAIL int_retake: d_en/ci/ack=%b want 111", {d_en, cpu_interrupt, int_ack});
        end
        @(negedge gclk); int_req = 1'b0;
        #1;
        tests_run++;
        if ({cpu_interrupt, int_ack} !== 2'b00) begin
            fails++;
            $display("FAIL int_after: ci/ack=%b want 00", {cpu_interrupt, int_ack});
        end
    endtask

    task automatic test_int_busy();
        @(negedge gclk); int_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk);
            icache_busy = (i < 3);
            #1;
            tests_run++;
            if ({d_en, cpu_interrupt, int_ack} !== ((i < 3) ? 3'b010 : 3'b111)) begin
                fails++;
                $display("FAIL int_busy[%0d]: d_en/ci/ack=%b want %b", i,
                         {d_en, cpu_interrupt, int_ack}, (i < 3) ? 3'b010 : 3'b111);
            end
        end
        @(negedge gclk); int_req = 1'b0;
        #1;
        tests_run++;
        if ({d_en, cpu_interrupt, int_ack} !== 3'b100) begin
            fails++;
            $display("FAIL int_busy_end: d_en/ci/ack=%b want 100", {d_en, cpu_interrupt, int_ack});
        end
    endtask

    task automatic test_prio_and_reset();
        logic [2:0] exp [5] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b111};
        for (int i = 0; i < 5; i++) begin
            @(negedge gclk);
            fSTALL  = (i == 0);
            int_req = 1'b1;
            #1;
            tests_run++;
            if ({d_en, cpu_interrupt, int_ack} !== exp[i]) begin
                fails++;
                $display("FAIL prio[%0d]: d_en/ci/ack=%b want %b", i, {d_en, cpu_interrupt, int_ack}, exp[i]);
            end
        end
        @(negedge gclk); int_req = 1'b0; fSTALL = 1'b1;
        @(negedge gclk); fSTALL = 1'b0; grst = 1'b0;
        #1;
        tests_run++;
        if (d_en !== 1'b0) begin
            fails++;
            $display("FAIL rst_mcop_pre: d_en=%b want 0", d_en);
        end
        @(negedge gclk); grst = 1'b1;
        #1;
        tests_run++;
        if ({d_en, cpu_interrupt, int_ack} !== 3'b100 || stall_cycles !== 16'd0) begin
            fails++;
            $display("FAIL rst_mcop: d_en/ci/ack=%b stall=%0d want 100 stall=0",
                     {d_en, cpu_interrupt, int_ack}, stall_cycles);
        end
        @(negedge gclk); int_req = 1'b1;
        @(negedge gclk); icache_busy = 1'b1; grst = 1'b0;
        #1;
        tests_run++;
        if ({d_en, cpu_interrupt, int_ack} !== 3'b010) begin
            fails++;
            $display("FAIL rst_int_pre: d_en/ci/ack=%b want 010", {d_en, cpu_interrupt, int_ack});
        end
        @(negedge gclk); icache_busy = 1'b0; grst = 1'b1; int_req = 1'b0;
        #1;
        tests_run++;
        if ({d_en, cpu_interrupt, int_ack} !== 3'b100) begin
            fails++;
            $display("FAIL rst_int: d_en/ci/ack=%b want 100", {d_en, cpu_interrupt, int_ack});
        end
    endtask

    task automatic test_saturation();
        @(negedge gclk); perf_clr = 1'b1;
        @(negedge gclk); perf_clr = 1'b0;
        #1;
        tests_run++;
        if (stall4 !== 4'd0 || stall_cycles !== 16'd0) begin
            fails++;
            $display("FAIL sat_clr: stall4=%0d stall=%0d want 0/0", stall4, stall_cycles);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge gclk); dcache_busy = 1'b1;
        end
        @(negedge gclk); dcache_busy = 1'b0;
        #1;
        tests_run++;
        if (stall4 !== 4'd15 || stall_cycles !== 16'd20) begin
            fails++;
            $display("FAIL saturate: stall4=%0d stall=%0d want 15/20", stall4, stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_mcop();
        test_busy();
        test_int_dslot();
        test_int_busy();
        test_prio_and_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/aexm_pipe_sched.md
Name: aexm_pipe_sched

Overview:
- Pipeline sequencer for the AEXM core.
- Generates the pipeline advance enables d_en/x_en consumed by the instruction/control pipeline.
- Holds the pipeline for multi-cycle ops flagged by fSTALL and for instruction/data cache busy.
- Injects the cpu_interrupt pseudo-branch into decode at a safe boundary; keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MC_CYCLES, 3, total cycles a multi-cycle op (fSTALL) occupies; legal range 2..15.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- gclk  input  1  clock
- grst  input  1  reset, synchronous, active-low
- fSTALL  input  1  decode holds a multi-cycle op (combinational from decode IREG)
- icache_busy  input  1  instruction cache cannot deliver this cycle
- dcache_busy  input  1  data cache miss/fill in progress
- in_dslot  input  1  decode instruction is a branch delay slot
- int_req  input  1  level interrupt request from the interrupt controller
- int_enable  input  1  MSR IE bit
- perf_clr  input  1  synchronous clear of stall_cycles
- d_en  output  1  decode-stage advance enable
- x_en  output  1  execute-stage advance enable
- cpu_interrupt  output  1  force interrupt branch into decode
- int_ack  output  1  one-cycle pulse, interrupt taken
- stall_cycles  output  STALL_CNT_W  saturating count of cycles with d_en=0

Behaviour:
- State machine: RUN, MCOP, INT.
- Counter mc_cnt is 4 bits wide. Flag int_armed is 1 bit.
- Define busy = icache_busy | dcache_busy.

Enables:
- d_en = x_en, always identical.
- d_en = (state==RUN || state==INT) && !busy. It is 0 in MCOP.
- d_en is combinational from state and the busy inputs. No path from fSTALL or int_req to d_en.

RUN state:
- If !busy && fSTALL: the op advances this cycle. Go to MCOP with mc_cnt = MC_CYCLES-2.
- Else if !busy && int_req && int_enable && int_armed && !in_dslot: go to INT.
- fSTALL has priority over an interrupt in the same cycle.
- If busy, stay in RUN. Nothing is accepted.

MCOP state:
- d_en = 0.
- If mc_cnt==0, go to RUN; else decrement mc_cnt.
- MCOP therefore lasts MC_CYCLES-1 cycles. Total op occupancy, including the advance cycle, is MC_CYCLES.
- busy does not extend MCOP. Busy is re-evaluated in RUN.

INT state:
- cpu_interrupt = 1 (registered, state-decoded).
- When d_en=1 in INT:
  - int_ack = 1 in that same cycle;
  - int_armed <= 0;
  - go to RUN.
- If busy, remain in INT with cpu_interrupt held until the advance happens.
- Exactly one decode advance occurs with cpu_interrupt=1 per accepted interrupt.

Interrupt re-arm:
- int_armed <= 1 whenever int_req==0.
- A held-high level request is taken once. It must drop before it can be retaken.

stall_cycles:
- Increments when d_en==0. Saturates at all-ones, no wrap.
- perf_clr sets it to 0 and has priority over increment.

Reset (grst==0, synchronous):
- state=RUN, mc_cnt=0, int_armed=1, stall_cycles=0.
- Outputs after reset: cpu_interrupt=0, int_ack=0. d_en=x_en=!busy.
- Reset mid-MCOP or mid-INT aborts the operation. No int_ack is issued.

Timing:
- Zero latency from busy to d_en deassertion.
- One cycle from acceptance in RUN to cpu_interrupt.

Test Plan:
- Reset then idle (busy=0, fSTALL=0, int_req=0) -> d_en=x_en=1 every cycle, stall_cycles stays 0, cpu_interrupt=int_ack=0.
- fSTALL=1 for one cycle in RUN, MC_CYCLES=3 -> d_en=1 on that cycle, then 0 for exactly 2 cycles, then 1; stall_cycles=2.
- dcache_busy=1 for 5 cycles during RUN -> d_en=0 for exactly those 5 cycles; stall_cycles +5. Then perf_clr=1 -> stall_cycles=0 on next cycle.
- int_req=1, int_enable=1, in_dslot=1 for 2 cycles, then in_dslot=0 -> no acceptance while in_dslot=1. Next cycle cpu_interrupt=1 with int_ack=1 for one cycle. int_req held high for 10 more cycles -> no second int_ack. int_req=0 for one cycle, then 1 -> taken again.
- Interrupt accepted, then icache_busy=1 for 3 cycles while in INT -> cpu_interrupt held 4 cycles, int_ack only on the 4th (d_en=1) cycle.
- fSTALL=1 and int_req=1 in the same RUN cycle -> MCOP first (d_en 1,0,0). Interrupt taken on the following RUN cycle. Separately, assert grst=0 mid-MCOP -> state RUN, d_en=1 next cycle, stall_cycles=0, no int_ack.
- STALL_CNT_W=4, hold dcache_busy=1 for 20 cycles -> stall_cycles saturates at 15.
